// File: rtl/alu_16_pkg.sv
// Shared types and opcode encodings for the 16-bit execute-stage ALU.
package alu_16_pkg;

    localparam int unsigned DATA_W  = 16;
    localparam int unsigned OP_W    = 3;
    localparam int unsigned SHAMT_W = 4;

    typedef enum logic [OP_W-1:0] {
        ALU_ADD  = 3'b000,
        ALU_SUB  = 3'b001,
        ALU_AND  = 3'b010,
        ALU_OR   = 3'b011,
        ALU_NAND = 3'b100,
        ALU_XOR  = 3'b101,
        ALU_SLL  = 3'b110,
        ALU_SRA  = 3'b111
    } alu_op_e;

    typedef struct packed {
        logic z;
        logic v;
        logic n;
    } alu_flags_t;

endpackage

// File: rtl/alu_16_addsub.sv
// 16-bit adder/subtractor: SUB is a + ~b + 1, overflow from operand/result signs.
module alu_16_addsub
    import alu_16_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              sub,
    output logic [DATA_W-1:0] sum,
    output logic              ovf
);

    logic [DATA_W-1:0] b_eff;

    assign b_eff = sub ? ~b : b;
    assign sum   = a + b_eff + DATA_W'(sub);

    // Same-signed effective operands producing a differently-signed result.
    assign ovf = (a[DATA_W-1] == b_eff[DATA_W-1]) && (sum[DATA_W-1] != a[DATA_W-1]);

endmodule

// File: rtl/alu_16.sv
// Execute-stage ALU: combinational result and Z/V/N flags, plus a flag status register.
module alu_16
    import alu_16_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [OP_W-1:0]   alu_op,
    input  logic [DATA_W-1:0] alu_a,
    input  logic [DATA_W-1:0] alu_b,
    output logic [DATA_W-1:0] alu_out,
    output logic              z,
    output logic              v,
    output logic              n,
    input  logic              flag_we,
    output logic              sr_z,
    output logic              sr_v,
    output logic              sr_n
);

    logic [DATA_W-1:0]        as_sum;
    logic                     as_ovf;
    logic                     is_sub;
    logic [SHAMT_W-1:0]       shamt;
    logic signed [DATA_W-1:0] a_signed;

    assign is_sub   = (alu_op == ALU_SUB);
    assign shamt    = alu_b[SHAMT_W-1:0];
    assign a_signed = alu_a;

    alu_16_addsub u_addsub (
        .a   (alu_a),
        .b   (alu_b),
        .sub (is_sub),
        .sum (as_sum),
        .ovf (as_ovf)
    );

    // Result mux; every opcode is decoded so the output is always defined.
    always_comb begin
        alu_out = '0;
        v       = 1'b0;
        case (alu_op_e'(alu_op))
            ALU_ADD: begin
                alu_out = as_sum;
                v       = as_ovf;
            end
            ALU_SUB: begin
                alu_out = as_sum;
                v       = as_ovf;
            end
            ALU_AND:  alu_out = alu_a & alu_b;
            ALU_OR:   alu_out = alu_a | alu_b;
            ALU_NAND: alu_out = ~(alu_a & alu_b);
            ALU_XOR:  alu_out = alu_a ^ alu_b;
            ALU_SLL:  alu_out = alu_a << shamt;
            ALU_SRA:  alu_out = DATA_W'(a_signed >>> shamt);
            default:  alu_out = '0;
        endcase
    end

    assign z = (alu_out == '0);
    assign n = alu_out[DATA_W-1];

    // Status register; reset takes priority over a flag write.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sr_z <= 1'b0;
            sr_v <= 1'b0;
            sr_n <= 1'b0;
        end else if (flag_we) begin
            sr_z <= z;
            sr_v <= v;
            sr_n <= n;
        end
    end

endmodule

// File: tb/tb_alu_16.sv
// Self-checking bench for alu_16: directed corner vectors plus random ops against a reference model.
module tb_alu_16;
    import alu_16_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [2:0]  alu_op;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [15:0] alu_out;
    logic        z, v, n;
    logic        flag_we;
    logic        sr_z, sr_v, sr_n;

    int tests = 0;
    int fails = 0;

    alu_16 dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .alu_op  (alu_op),
        .alu_a   (alu_a),
        .alu_b   (alu_b),
        .alu_out (alu_out),
        .z       (z),
        .v       (v),
        .n       (n),
        .flag_we (flag_we),
        .sr_z    (sr_z),
        .sr_v    (sr_v),
        .sr_n    (sr_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: signed integer arithmetic, overflow as out-of-range result.
    function automatic logic [18:0] model(input logic [2:0] op, input logic [15:0] a,
                                          input logic [15:0] b);
        int          sa, sb, r;
        logic [15:0] o;
        logic        ov;
        int          sh;
        sa = $signed(a);
        sb = $signed(b);
        sh = int'(b[3:0]);
        ov = 1'b0;
        r  = 0;
        case (op)
            3'd0: begin r = sa + sb; ov = (r > 32767) || (r < -32768); end
            3'd1: begin r = sa - sb; ov = (r > 32767) || (r < -32768); end
            3'd2: r = int'(a & b);
            3'd3: r = int'(a | b);
            3'd4: r = int'(~(a & b));
            3'd5: r = int'(a ^ b);
            3'd6: r = int'(a) * (1 << sh);
            default: r = sa >>> sh;
        endcase
        o = r[15:0];
        return {o, (o == 16'h0000), ov, o[15]};
    endfunction

    task automatic test_reset();
        @(negedge clk);
        rst_n   = 1'b0;
        flag_we = 1'b1;
        alu_op  = 3'd4; alu_a = 16'h0003; alu_b = 16'h0005;
        @(posedge clk); #1;
        tests++;
        if ({sr_z, sr_v, sr_n} !== 3'b000) begin
            fails++;
            $display("FAIL reset_sr: got %b expected 000", {sr_z, sr_v, sr_n});
        end
        tests++;
        if ({alu_out, z, v, n} !== {16'hFFFE, 3'b001}) begin
            fails++;
            $display("FAIL comb_during_reset: got %h/%b expected fffe/001", alu_out, {z, v, n});
        end
        @(negedge clk);
        rst_n   = 1'b1;
        flag_we = 1'b0;
    endtask

    task automatic test_directed();
        logic [2:0]  ops [10] = '{3'd4, 3'd4, 3'd0, 3'd0, 3'd1, 3'd1, 3'd6, 3'd7, 3'd7, 3'd6};
        logic [15:0] as  [10] = '{16'h0003, 16'hFFFF, 16'h7FFF, 16'hFFFF, 16'h8000,
                                  16'h1234, 16'h0001, 16'h8000, 16'h8000, 16'h1234};
        logic [15:0] bs  [10] = '{16'h0005, 16'hFFFF, 16'h0001, 16'h0001, 16'h0001,
                                  16'h1234, 16'h0013, 16'h0004, 16'h000F, 16'hFFF0};
        logic [18:0] exp [10] = '{{16'hFFFE, 3'b001}, {16'h0000, 3'b100}, {16'h8000, 3'b011},
                                  {16'h0000, 3'b100}, {16'h7FFF, 3'b010}, {16'h0000, 3'b100},
                                  {16'h0008, 3'b000}, {16'hF800, 3'b001}, {16'hFFFF, 3'b001},
                                  {16'h1234, 3'b000}};
        for (int i = 0; i < 10; i++) begin
            alu_op = ops[i]; alu_a = as[i]; alu_b = bs[i];
            #1;
            tests++;
            if ({alu_out, z, v, n} !== exp[i]) begin
                fails++;
                $display("FAIL directed[%0d]: got out=%h zvn=%b expected out=%h zvn=%b",
                         i, alu_out, {z, v, n}, exp[i][18:3], exp[i][2:0]);
            end
        end
    endtask

    task automatic test_status();
        @(negedge clk);
        flag_we = 1'b1;
        alu_op  = 3'd4; alu_a = 16'hFFFF; alu_b = 16'hFFFF;
        @(posedge clk); #1;
        tests++;
        if ({sr_z, sr_v, sr_n} !== 3'b100) begin
            fails++;
            $display("FAIL sr_capture: got %b expected 100", {sr_z, sr_v, sr_n});
        end
        @(negedge clk);
        flag_we = 1'b0;
        alu_op  = 3'd0; alu_a = 16'h7FFF; alu_b = 16'h0001;
        @(posedge clk); #1;
        tests++;
        if ({sr_z, sr_v, sr_n} !== 3'b100) begin
            fails++;
            $display("FAIL sr_hold: got %b expected 100", {sr_z, sr_v, sr_n});
        end
        @(negedge clk);
        flag_we = 1'b1;
        @(posedge clk); #1;
        tests++;
        if ({sr_z, sr_v, sr_n} !== 3'b011) begin
            fails++;
            $display("FAIL sr_overflow_capture: got %b expected 011", {sr_z, sr_v, sr_n});
        end
    endtask

    task automatic test_random();
        logic [18:0] e;
        logic [2:0]  sr_exp;
        sr_exp = {sr_z, sr_v, sr_n};
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            alu_op  = 3'($urandom_range(0, 7));
            alu_a   = 16'($urandom);
            alu_b   = (i % 4 == 0) ? 16'($urandom_range(0, 15)) : 16'($urandom);
            if (i % 10 == 0) alu_a = (i % 20 == 0) ? 16'h8000 : 16'h7FFF;
            flag_we = 1'($urandom_range(0, 1));
            e = model(alu_op, alu_a, alu_b);
            #1;
            tests++;
            if ({alu_out, z, v, n} !== e) begin
                fails++;
                $display("FAIL random[%0d] op=%0d a=%h b=%h: got out=%h zvn=%b expected out=%h zvn=%b",
                         i, alu_op, alu_a, alu_b, alu_out, {z, v, n}, e[18:3], e[2:0]);
            end
            if (flag_we) sr_exp = e[2:0];
            @(posedge clk); #1;
            tests++;
            if ({sr_z, sr_v, sr_n} !== sr_exp) begin
                fails++;
                $display("FAIL random_sr[%0d]: got %b expected %b", i, {sr_z, sr_v, sr_n}, sr_exp);
            end
        end
    endtask

    initial begin
        rst_n   = 1'b1;
        flag_we = 1'b0;
        alu_op  = 3'd0;
        alu_a   = 16'h0000;
        alu_b   = 16'h0000;
        test_reset();
        test_directed();
        test_status();
        test_random();
        test_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
